imem_loader: RTL and testbench

- Boot-time program loader: the write side of the instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction RAM and checks a frame checksum.
- Holds the pipelined core in reset (cpu_hold) until a complete, checksum-clean image is loaded.

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader and the write side of the instruction memory.
// It accepts a framed byte stream over a valid/ready handshake:
//   SYNC_BYTE, LEN_LO, LEN_HI, N*4 data bytes (little-endian words), CHECKSUM
// It assembles 32-bit instruction words and writes each one into the
// instruction RAM. It also holds the core in reset until a complete image
// with a matching checksum has been loaded.
//
// Handshake: a byte moves only in a cycle where in_valid && in_ready are
// both 1 at the rising edge. in_ready is a registered decode of the state
// and never looks at in_valid. The producer must keep in_data stable while
// in_valid is high and in_ready is low.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   start      one-cycle pulse; begins a frame from IDLE, DONE or ERR
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader accepts a byte this cycle
//   we         RAM write enable, one-cycle pulse per word
//   waddr      RAM word address (word index, not byte address)
//   wdata      instruction word
//   cpu_hold   keeps the core in reset; low only in DONE
//   done       image loaded and verified
//   error      frame rejected
//   dbg_state  current FSM state, for observation only
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int          ADDR_W    = 12,
  parameter int          DEPTH     = 4096,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_LEN_LO = 3'd2,
    S_LEN_HI = 3'd3,
    S_DATA   = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // One extra bit so that a 16-bit length can be compared against DEPTH
  // even when DEPTH is 65536.
  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  state_t            r_state;
  state_t            w_next;
  logic              r_in_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_error;
  logic [7:0]        r_csum;
  logic [1:0]        r_byte_cnt;
  logic [15:0]       r_word_idx;
  logic [15:0]       r_len;
  logic [23:0]       r_asm;       // bytes 0..2 of the word being built

  logic              w_xfer;
  logic              w_start_ok;
  logic              w_word_end;
  logic              w_last_word;
  logic [15:0]       w_len;

  assign w_xfer      = in_valid && r_in_ready;
  assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE ||
                                 r_state == S_ERR);
  // Full length as it stands on the LEN_HI byte.
  assign w_len       = {in_data, r_len[7:0]};
  assign w_word_end  = (r_state == S_DATA) && w_xfer && (r_byte_cnt == 2'd3);
  // DATA is entered only with a non-zero length, so r_len - 1 never wraps.
  assign w_last_word = (r_word_idx == r_len - 16'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_SYNC;
      S_SYNC:   if (w_xfer) w_next = (in_data == SYNC_BYTE) ? S_LEN_LO : S_ERR;
      S_LEN_LO: if (w_xfer) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_xfer) begin
          if (w_len == 16'd0)                w_next = S_CHECK;
          else if ({1'b0, w_len} > LP_DEPTH) w_next = S_ERR;
          else                               w_next = S_DATA;
        end
      end
      S_DATA:   if (w_word_end && w_last_word) w_next = S_CHECK;
      S_CHECK:  if (w_xfer) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_csum     <= '0;
      r_byte_cnt <= '0;
      r_word_idx <= '0;
      r_len      <= '0;
      r_asm      <= '0;
    end else begin
      r_state <= w_next;
      // Status outputs are registered from the next state, so each one
      // lines up exactly with the state it describes.
      r_in_ready <= (w_next == S_SYNC) || (w_next == S_LEN_LO) ||
                    (w_next == S_LEN_HI) || (w_next == S_DATA) ||
                    (w_next == S_CHECK);
      r_done     <= (w_next == S_DONE);
      r_error    <= (w_next == S_ERR);
      r_cpu_hold <= (w_next != S_DONE);
      // A word completes at most once every four accepted bytes, so this
      // pulse can never last two cycles.
      r_we       <= w_word_end;

      if (w_start_ok) begin
        r_csum     <= '0;
        r_byte_cnt <= '0;
        r_word_idx <= '0;
        r_len      <= '0;
      end else begin
        if (r_state == S_LEN_LO && w_xfer) r_len[7:0]  <= in_data;
        if (r_state == S_LEN_HI && w_xfer) r_len[15:8] <= in_data;
        if (r_state == S_DATA && w_xfer) begin
          r_csum     <= r_csum + in_data;
          r_byte_cnt <= r_byte_cnt + 2'd1;
          case (r_byte_cnt)
            2'd0:    r_asm[7:0]   <= in_data;
            2'd1:    r_asm[15:8]  <= in_data;
            2'd2:    r_asm[23:16] <= in_data;
            default: ;
          endcase
        end
        // The fourth byte goes straight into the word, which saves a cycle
        // and lets back-to-back bytes write one word every four cycles.
        if (w_word_end) begin
          r_waddr    <= r_word_idx[ADDR_W-1:0];
          r_wdata    <= {in_data, r_asm};
          r_word_idx <= r_word_idx + 16'd1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign we        = r_we;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign error     = r_error;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader: directed testbench for imem_loader (ADDR_W=12, DEPTH=4096).
// ---------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [43:0] exp_q[$];   // {waddr, wdata}
  logic [43:0] cap_q[$];
  logic [7:0]  tx_q[$];
  int          start_at;   // index of the byte sent together with a start pulse
  int          we_twice = 0;
  int          both_flags = 0;
  logic        prev_we = 1'b0;

  imem_loader #(.ADDR_W(12), .DEPTH(4096), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  // Clock and write monitor (samples on the falling edge)
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) cap_q.push_back({waddr, wdata});
    if (we && prev_we) we_twice++;
    if (done && error) both_flags++;
    prev_we = we;
  end

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present one byte; returns on the falling edge before the rising edge
  // that consumes it.
  task automatic send_byte(input logic [7:0] b, input bit stall, input bit st);
    int t;
    if (stall && $urandom_range(0, 1) == 1) begin
      @(negedge clk); in_valid = 1'b0; start = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = b; start = st;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk); start = 1'b0; t++;
    end
    if (t >= 20) begin
      vectors++; miscompares++;
      $display("FAIL send_byte_timeout byte=%h in_ready stayed %b, required 1", b, in_ready);
    end
  endtask

  task automatic send_frame(input bit stall);
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], stall, i == start_at);
    @(negedge clk); in_valid = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_two_word(input logic [7:0] chk);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h0F, 8'h00, 8'h4F, 8'hE0,
             8'h05, 8'h20, 8'h80, 8'hE2, chk};
    exp_q = '{{12'd0, 32'hE04F000F}, {12'd1, 32'hE2802005}};
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset(); @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b exp 0", we); end
    vectors++; if (waddr !== 12'd0) begin miscompares++; $display("FAIL reset_waddr got %h exp 000", waddr); end
    vectors++; if (wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata got %h exp 00000000", wdata); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_hold got %b exp 1", cpu_hold); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b exp 0", error); end
    vectors++; if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_load(input string name, input logic [7:0] chk, input bit stall,
                           input int st_at, input logic exp_done);
    do_reset(); cap_q.delete();
    load_two_word(chk); start_at = st_at;
    pulse_start(); send_frame(stall);
    vectors++;
    if (cap_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL %s_write_count got %0d exp %0d", name, cap_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (cap_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL %s_write%0d got %h exp %h", name, i, cap_q[i], exp_q[i]);
        end
      end
    end
    vectors++; if (done !== exp_done) begin miscompares++; $display("FAIL %s_done got %b exp %b", name, done, exp_done); end
    vectors++; if (error !== !exp_done) begin miscompares++; $display("FAIL %s_error got %b exp %b", name, error, !exp_done); end
    vectors++; if (cpu_hold !== !exp_done) begin miscompares++; $display("FAIL %s_cpu_hold got %b exp %b", name, cpu_hold, !exp_done); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL %s_in_ready got %b exp 0", name, in_ready); end
  endtask

  task automatic test_framing_errors();
    // Bad sync byte, then over-long length 0x1001
    for (int k = 0; k < 2; k++) begin
      do_reset(); cap_q.delete(); start_at = -1;
      if (k == 0) tx_q = '{8'h5A};
      else        tx_q = '{8'hA5, 8'h01, 8'h10};
      pulse_start(); send_frame(1'b0);
      vectors++; if (cap_q.size() !== 0) begin miscompares++; $display("FAIL frame_err%0d_writes got %0d exp 0", k, cap_q.size()); end
      vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL frame_err%0d_error got %b exp 1", k, error); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL frame_err%0d_done got %b exp 0", k, done); end
      vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL frame_err%0d_cpu_hold got %b exp 1", k, cpu_hold); end
      vectors++; if (dbg_state !== 3'd7) begin miscompares++; $display("FAIL frame_err%0d_state got %0d exp 7", k, dbg_state); end
    end
  endtask

  task automatic test_zero_length();
    do_reset(); cap_q.delete(); start_at = -1;
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    pulse_start(); send_frame(1'b0);
    vectors++; if (cap_q.size() !== 0) begin miscompares++; $display("FAIL zero_len_writes got %0d exp 0", cap_q.size()); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_len_done got %b exp 1", done); end
    vectors++; if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL zero_len_cpu_hold got %b exp 0", cpu_hold); end
  endtask

  task automatic test_reset_mid_data();
    do_reset(); cap_q.delete();
    pulse_start();
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h0F, 8'h00};
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    vectors++; if (dbg_state !== 3'd0) begin miscompares++; $display("FAIL mid_reset_state got %0d exp 0", dbg_state); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset_in_ready got %b exp 0", in_ready); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL mid_reset_cpu_hold got %b exp 1", cpu_hold); end
    vectors++; if ({waddr, wdata} !== 44'd0) begin miscompares++; $display("FAIL mid_reset_wport got %h exp 0", {waddr, wdata}); end
    repeat (4) @(negedge clk);
    vectors++; if (cap_q.size() !== 0) begin miscompares++; $display("FAIL mid_reset_writes got %0d exp 0", cap_q.size()); end
    // A fresh frame after the aborted one loads from word 0
    load_two_word(8'hC5); start_at = -1;
    pulse_start(); send_frame(1'b0);
    vectors++; if (cap_q.size() !== 2) begin miscompares++; $display("FAIL reload_write_count got %0d exp 2", cap_q.size()); end
    else begin
      vectors++; if (cap_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL reload_write0 got %h exp %h", cap_q[0], exp_q[0]); end
      vectors++; if (cap_q[1] !== exp_q[1]) begin miscompares++; $display("FAIL reload_write1 got %h exp %h", cap_q[1], exp_q[1]); end
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL reload_done got %b exp 1", done); end
  endtask

  task automatic test_restart_after_done();
    // Continues from DONE left by the previous scenario
    cap_q.delete();
    pulse_start();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL restart_done got %b exp 0", done); end
    vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL restart_cpu_hold got %b exp 1", cpu_hold); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL restart_in_ready got %b exp 1", in_ready); end
    vectors++; if (dbg_state !== 3'd1) begin miscompares++; $display("FAIL restart_state got %0d exp 1", dbg_state); end
    // One word 0x12345678, checksum 78+56+34+12 = 0x114 -> 0x14
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
    start_at = -1;
    send_frame(1'b0);
    vectors++; if (cap_q.size() !== 1) begin miscompares++; $display("FAIL restart_write_count got %0d exp 1", cap_q.size()); end
    else begin
      vectors++; if (cap_q[0] !== {12'd0, 32'h12345678}) begin miscompares++; $display("FAIL restart_write0 got %h exp 00012345678", cap_q[0]); end
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL restart_final_done got %b exp 1", done); end
  endtask

  task automatic test_invariants();
    vectors++; if (we_twice !== 0) begin miscompares++; $display("FAIL we_consecutive got %0d exp 0", we_twice); end
    vectors++; if (both_flags !== 0) begin miscompares++; $display("FAIL done_and_error got %0d exp 0", both_flags); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; start_at = -1;
    test_reset();
    test_load("normal", 8'hC5, 1'b0, -1, 1'b1);
    test_load("bad_csum", 8'hC4, 1'b0, -1, 1'b0);
    test_framing_errors();
    test_load("stall", 8'hC5, 1'b1, -1, 1'b1);
    test_zero_length();
    test_reset_mid_data();
    test_restart_after_done();
    test_load("start_busy", 8'hC5, 1'b0, 5, 1'b1);
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
